// File: rtl/mul_int_if.sv
// Handshake and result bundle for the sequential Booth multiplier.
interface mul_int_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  en;
  logic                  opcode;
  logic [DATA_WIDTH-1:0] multiplicand;
  logic [DATA_WIDTH-1:0] multiplier;
  logic                  busy;
  logic                  almost_valid;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] product_lo;
  logic [DATA_WIDTH-1:0] product_hi;

  modport master (
    output en, opcode, multiplicand, multiplier,
    input  busy, almost_valid, valid_out, product_lo, product_hi
  );

  modport slave (
    input  en, opcode, multiplicand, multiplier,
    output busy, almost_valid, valid_out, product_lo, product_hi
  );
endinterface

// File: rtl/mul_int.sv
// Sequential radix-2 Booth multiplier: W+1 steps over (W+1)-bit extended operands,
// one load cycle, then a one-cycle valid pulse. Signed or unsigned per opcode.
module mul_int #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic   clock,
  input logic   reset,
  mul_int_if.slave bus
);
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(W) + 2;

  typedef enum logic {StIdle, StRun} state_e;

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [W+1:0]    mcand;    // extended multiplicand, one guard bit above W+1
  logic [W+1:0]    acc;
  logic [W:0]      mplr;
  logic            mplr_m1;
  logic            almost_valid;
  logic            valid_out;
  logic [W-1:0]    product_lo;
  logic [W-1:0]    product_hi;
  logic [W+1:0]    addend;
  logic [W+1:0]    sum;

  always_comb begin
    addend = '0;
    case ({mplr[0], mplr_m1})
      2'b01:   addend = mcand;
      2'b10:   addend = ~mcand + (W+2)'(1);
      default: addend = '0;
    endcase
    sum = acc + addend;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= StIdle;
      cnt          <= '0;
      mcand        <= '0;
      acc          <= '0;
      mplr         <= '0;
      mplr_m1      <= 1'b0;
      almost_valid <= 1'b0;
      valid_out    <= 1'b0;
      product_lo   <= '0;
      product_hi   <= '0;
    end else begin
      almost_valid <= 1'b0;
      valid_out    <= 1'b0;
      case (state)
        StIdle: begin
          cnt <= '0;
          if (bus.en) begin
            mcand   <= {{2{bus.opcode & bus.multiplicand[W-1]}}, bus.multiplicand};
            mplr    <= {bus.opcode & bus.multiplier[W-1], bus.multiplier};
            acc     <= '0;
            mplr_m1 <= 1'b0;
            state   <= StRun;
          end
        end
        StRun: begin
          if (cnt == CW'(W + 1)) begin
            // {acc, mplr} holds the full product; keep its low 2W bits
            product_lo <= mplr[W-1:0];
            product_hi <= {acc[W-2:0], mplr[W]};
            valid_out  <= 1'b1;
            cnt        <= '0;
            state      <= StIdle;
          end else begin
            acc     <= {sum[W+1], sum[W+1:1]};
            mplr    <= {sum[0], mplr[W:1]};
            mplr_m1 <= mplr[0];
            cnt     <= cnt + CW'(1);
            if (cnt == CW'(W)) almost_valid <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.busy         = (state == StRun);
  assign bus.almost_valid = almost_valid;
  assign bus.valid_out    = valid_out;
  assign bus.product_lo   = product_lo;
  assign bus.product_hi   = product_hi;
endmodule
